// File: rtl/alu_result_collector_if.sv
// Result-side bus of alu_result_collector: ALU unit result/flag inputs and the valid/ready FIFO head.
// RES_PAR exists only when ALU_RES_PARITY_EN is defined.
interface alu_result_collector_if #(
    parameter int unsigned OP_DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH    = 4
);
    localparam int unsigned DATA_W = 2 * OP_DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0]        Arith_OUT;
    logic                     Arith_Flag;
    logic [OP_DATA_WIDTH-1:0] Logic_OUT;
    logic                     Logic_Flag;
    logic [OP_DATA_WIDTH:0]   Shift_OUT;
    logic                     Shift_Flag;
    logic [1:0]               CMP_OUT;
    logic                     CMP_Flag;
    logic                     RES_READY;
    logic                     OVF_CLR;
    logic                     RES_VALID;
    logic [DATA_W-1:0]        RES_DATA;
    logic [1:0]               RES_UNIT;
    logic [CNT_W-1:0]         FIFO_COUNT;
    logic                     OVF;
    logic                     MULTI_ERR;
`ifdef ALU_RES_PARITY_EN
    logic                     RES_PAR;
`endif

    modport master (
`ifdef ALU_RES_PARITY_EN
        input  RES_PAR,
`endif
        output Arith_OUT, Arith_Flag, Logic_OUT, Logic_Flag,
        output Shift_OUT, Shift_Flag, CMP_OUT, CMP_Flag,
        output RES_READY, OVF_CLR,
        input  RES_VALID, RES_DATA, RES_UNIT, FIFO_COUNT, OVF, MULTI_ERR
    );

    modport slave (
`ifdef ALU_RES_PARITY_EN
        output RES_PAR,
`endif
        input  Arith_OUT, Arith_Flag, Logic_OUT, Logic_Flag,
        input  Shift_OUT, Shift_Flag, CMP_OUT, CMP_Flag,
        input  RES_READY, OVF_CLR,
        output RES_VALID, RES_DATA, RES_UNIT, FIFO_COUNT, OVF, MULTI_ERR
    );
endinterface

// File: rtl/alu_result_collector.sv
// Collects ALU unit results by fixed priority, zero-extends and tags them, and queues them in a show-ahead FIFO.
// Optional ALU_RES_PARITY_EN adds a stored even-parity bit exposed as RES_PAR.
module alu_result_collector #(
    parameter int unsigned OP_DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input logic                   CLK,
    input logic                   RST,
    alu_result_collector_if.slave bus
);
    localparam int unsigned DATA_W = 2 * OP_DATA_WIDTH;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
`ifdef ALU_RES_PARITY_EN
        logic              par;
`endif
        logic [1:0]        unit;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem_q [FIFO_DEPTH];
    entry_t            head_q, head_d;
    entry_t            sel_c;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              multi_q, multi_d;

    logic [3:0] flags_c;
    logic       push_req_c;
    logic       multi_evt_c;
    logic       pop_c;
    logic       full_c;
    logic       push_ok_c;
    logic       drop_c;

    assign flags_c     = {bus.Arith_Flag, bus.Logic_Flag, bus.Shift_Flag, bus.CMP_Flag};
    assign push_req_c  = |flags_c;
    assign multi_evt_c = $countones(flags_c) > 1;
    assign pop_c       = valid_q & bus.RES_READY;
    assign full_c      = (count_q == FULL_CNT);
    assign push_ok_c   = push_req_c & (~full_c | pop_c);
    assign drop_c      = push_req_c & full_c & ~pop_c;

    // Fixed priority Arith > Logic > Shift > CMP, zero-extended to the common width.
    always_comb begin
        sel_c = '0;
        if (bus.Arith_Flag) begin
            sel_c.unit = 2'b00;
            sel_c.data = bus.Arith_OUT;
        end else if (bus.Logic_Flag) begin
            sel_c.unit = 2'b01;
            sel_c.data = DATA_W'(bus.Logic_OUT);
        end else if (bus.Shift_Flag) begin
            sel_c.unit = 2'b11;
            sel_c.data = DATA_W'(bus.Shift_OUT);
        end else if (bus.CMP_Flag) begin
            sel_c.unit = 2'b10;
            sel_c.data = DATA_W'(bus.CMP_OUT);
        end
`ifdef ALU_RES_PARITY_EN
        sel_c.par = ^{sel_c.unit, sel_c.data};
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Next head is the entry being written when it lands in the slot the read pointer moves to.
        if (count_d != '0) begin
            if (push_ok_c && (wr_ptr_q == rd_ptr_d)) begin
                head_d = sel_c;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
        valid_d = (count_d != '0);
        ovf_d   = (ovf_q & ~bus.OVF_CLR) | drop_c;
        multi_d = (multi_q & ~bus.OVF_CLR) | multi_evt_c;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            multi_q  <= multi_d;
        end
    end

    // Entry storage is intentionally left unreset.
    always_ff @(posedge CLK) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= sel_c;
        end
    end

    assign bus.RES_VALID  = valid_q;
    assign bus.RES_DATA   = head_q.data;
    assign bus.RES_UNIT   = head_q.unit;
    assign bus.FIFO_COUNT = count_q;
    assign bus.OVF        = ovf_q;
    assign bus.MULTI_ERR  = multi_q;
`ifdef ALU_RES_PARITY_EN
    assign bus.RES_PAR    = head_q.par;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: directed scenarios plus randomized traffic against a queue model.
module tb_alu_result_collector;
    localparam int unsigned OPW   = 16;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [1:0]  unit;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t exp_q[$];
    logic exp_ovf = 1'b0;
    logic exp_multi = 1'b0;

    alu_result_collector_if #(.OP_DATA_WIDTH(OPW), .FIFO_DEPTH(DEPTH)) bif ();

    alu_result_collector #(.OP_DATA_WIDTH(OPW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bif.Arith_Flag = 1'b0; bif.Logic_Flag = 1'b0;
        bif.Shift_Flag = 1'b0; bif.CMP_Flag   = 1'b0;
        bif.Arith_OUT  = '0;   bif.Logic_OUT  = '0;
        bif.Shift_OUT  = '0;   bif.CMP_OUT    = '0;
        bif.RES_READY  = 1'b0; bif.OVF_CLR    = 1'b0;
    endtask

    // Reference behaviour for the edge about to happen, from the current inputs.
    task automatic model_step();
        exp_t e;
        bit   pop, have;
        int   nflags;
        if (!rst_n) return;
        pop    = (exp_q.size() > 0) && bif.RES_READY;
        nflags = int'(bif.Arith_Flag) + int'(bif.Logic_Flag) + int'(bif.Shift_Flag) + int'(bif.CMP_Flag);
        have   = 1'b1;
        if      (bif.Arith_Flag) begin e.unit = 2'b00; e.data = bif.Arith_OUT; end
        else if (bif.Logic_Flag) begin e.unit = 2'b01; e.data = 32'(bif.Logic_OUT); end
        else if (bif.Shift_Flag) begin e.unit = 2'b11; e.data = 32'(bif.Shift_OUT); end
        else if (bif.CMP_Flag)   begin e.unit = 2'b10; e.data = 32'(bif.CMP_OUT); end
        else have = 1'b0;
        if (bif.OVF_CLR) begin exp_ovf = 1'b0; exp_multi = 1'b0; end
        if (nflags > 1) exp_multi = 1'b1;
        if (pop) void'(exp_q.pop_front());
        if (have) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(e);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_arith(input logic [31:0] v, input logic rdy);
        idle();
        bif.Arith_Flag = 1'b1; bif.Arith_OUT = v; bif.RES_READY = rdy;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #23;
        n_cmp += 6;
        if (bif.RES_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", bif.RES_VALID); end
        if (bif.RES_DATA !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", bif.RES_DATA); end
        if (bif.RES_UNIT !== 2'b00) begin n_err++; $display("FAIL reset_unit got %b want 00", bif.RES_UNIT); end
        if (bif.FIFO_COUNT !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bif.FIFO_COUNT); end
        if (bif.OVF !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", bif.OVF); end
        if (bif.MULTI_ERR !== 1'b0) begin n_err++; $display("FAIL reset_multi got %0b want 0", bif.MULTI_ERR); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_push();
        push_arith(32'h0000_0008, 1'b0);
        n_cmp += 4;
        if (bif.RES_VALID !== 1'b1) begin n_err++; $display("FAIL single_valid got %0b want 1", bif.RES_VALID); end
        if (bif.RES_DATA !== 32'h8) begin n_err++; $display("FAIL single_data got %h want 00000008", bif.RES_DATA); end
        if (bif.RES_UNIT !== 2'b00) begin n_err++; $display("FAIL single_unit got %b want 00", bif.RES_UNIT); end
        if (bif.FIFO_COUNT !== 3'd1) begin n_err++; $display("FAIL single_count got %0d want 1", bif.FIFO_COUNT); end
        idle(); bif.RES_READY = 1'b1; tick();
        n_cmp += 2;
        if (bif.RES_VALID !== 1'b0) begin n_err++; $display("FAIL single_pop_valid got %0b want 0", bif.RES_VALID); end
        if (bif.FIFO_COUNT !== 3'd0) begin n_err++; $display("FAIL single_pop_count got %0d want 0", bif.FIFO_COUNT); end
        idle();
    endtask

    task automatic test_ordering();
        logic [31:0] wd [3];
        logic [1:0]  wu [3];
        wd[0] = 32'h0000_FFFF; wu[0] = 2'b01;
        wd[1] = 32'h0001_0002; wu[1] = 2'b11;
        wd[2] = 32'h0000_0002; wu[2] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            idle();
            bif.RES_READY = 1'b1;
            if (i == 0) begin bif.Logic_Flag = 1'b1; bif.Logic_OUT = 16'hFFFF; end
            if (i == 1) begin bif.Shift_Flag = 1'b1; bif.Shift_OUT = 17'h1_0002; end
            if (i == 2) begin bif.CMP_Flag = 1'b1; bif.CMP_OUT = 2'b10; end
            tick();
            n_cmp += 2;
            if (bif.RES_DATA !== wd[i]) begin n_err++; $display("FAIL order_data[%0d] got %h want %h", i, bif.RES_DATA, wd[i]); end
            if (bif.RES_UNIT !== wu[i]) begin n_err++; $display("FAIL order_unit[%0d] got %b want %b", i, bif.RES_UNIT, wu[i]); end
        end
        idle(); bif.RES_READY = 1'b1; tick();
        n_cmp++;
        if (bif.RES_VALID !== 1'b0) begin n_err++; $display("FAIL order_drained got %0b want 0", bif.RES_VALID); end
        idle();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) push_arith(32'(i), 1'b0);
        idle();
        n_cmp += 2;
        if (bif.FIFO_COUNT !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", bif.FIFO_COUNT); end
        if (bif.OVF !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b want 1", bif.OVF); end
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (bif.RES_DATA !== 32'(i)) begin n_err++; $display("FAIL ovf_drain[%0d] got %h want %h", i, bif.RES_DATA, 32'(i)); end
            idle(); bif.RES_READY = 1'b1; tick();
        end
        idle(); bif.OVF_CLR = 1'b1; tick();
        n_cmp += 2;
        if (bif.OVF !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %0b want 0", bif.OVF); end
        if (bif.RES_VALID !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %0b want 0", bif.RES_VALID); end
        idle();
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 4; i++) push_arith(32'(i), 1'b0);
        push_arith(32'd5, 1'b1);
        idle();
        n_cmp += 2;
        if (bif.OVF !== 1'b0) begin n_err++; $display("FAIL fullpp_ovf got %0b want 0", bif.OVF); end
        if (bif.FIFO_COUNT !== 3'd4) begin n_err++; $display("FAIL fullpp_count got %0d want 4", bif.FIFO_COUNT); end
        for (int i = 2; i <= 5; i++) begin
            n_cmp++;
            if (bif.RES_DATA !== 32'(i)) begin n_err++; $display("FAIL fullpp_drain[%0d] got %h want %h", i, bif.RES_DATA, 32'(i)); end
            idle(); bif.RES_READY = 1'b1; tick();
        end
        idle();
    endtask

    task automatic test_multi_flag();
        idle();
        bif.Arith_Flag = 1'b1; bif.Arith_OUT = 32'h10;
        bif.Logic_Flag = 1'b1; bif.Logic_OUT = 16'h20;
        tick();
        idle();
        n_cmp += 4;
        if (bif.FIFO_COUNT !== 3'd1) begin n_err++; $display("FAIL multi_count got %0d want 1", bif.FIFO_COUNT); end
        if (bif.RES_DATA !== 32'h10) begin n_err++; $display("FAIL multi_data got %h want 00000010", bif.RES_DATA); end
        if (bif.RES_UNIT !== 2'b00) begin n_err++; $display("FAIL multi_unit got %b want 00", bif.RES_UNIT); end
        if (bif.MULTI_ERR !== 1'b1) begin n_err++; $display("FAIL multi_err got %0b want 1", bif.MULTI_ERR); end
        bif.RES_READY = 1'b1; bif.OVF_CLR = 1'b1; tick();
        idle();
        n_cmp++;
        if (bif.MULTI_ERR !== 1'b0) begin n_err++; $display("FAIL multi_clr got %0b want 0", bif.MULTI_ERR); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle();
            bif.Arith_Flag = ($urandom_range(3) == 0);
            bif.Logic_Flag = ($urandom_range(3) == 0);
            bif.Shift_Flag = ($urandom_range(3) == 0);
            bif.CMP_Flag   = ($urandom_range(3) == 0);
            bif.Arith_OUT  = $urandom;
            bif.Logic_OUT  = 16'($urandom);
            bif.Shift_OUT  = 17'($urandom);
            bif.CMP_OUT    = 2'($urandom);
            bif.RES_READY  = ($urandom_range(1) == 1);
            bif.OVF_CLR    = ($urandom_range(9) == 0);
            tick();
            n_cmp += 4;
            if (bif.RES_VALID !== (exp_q.size() > 0)) begin n_err++; $display("FAIL rnd_valid c=%0d got %0b want %0b", c, bif.RES_VALID, exp_q.size() > 0); end
            if (bif.FIFO_COUNT !== 3'(exp_q.size())) begin n_err++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, bif.FIFO_COUNT, exp_q.size()); end
            if (bif.OVF !== exp_ovf) begin n_err++; $display("FAIL rnd_ovf c=%0d got %0b want %0b", c, bif.OVF, exp_ovf); end
            if (bif.MULTI_ERR !== exp_multi) begin n_err++; $display("FAIL rnd_multi c=%0d got %0b want %0b", c, bif.MULTI_ERR, exp_multi); end
            if (exp_q.size() > 0) begin
                n_cmp += 2;
                if (bif.RES_DATA !== exp_q[0].data) begin n_err++; $display("FAIL rnd_data c=%0d got %h want %h", c, bif.RES_DATA, exp_q[0].data); end
                if (bif.RES_UNIT !== exp_q[0].unit) begin n_err++; $display("FAIL rnd_unit c=%0d got %b want %b", c, bif.RES_UNIT, exp_q[0].unit); end
`ifdef ALU_RES_PARITY_EN
                n_cmp++;
                if (bif.RES_PAR !== ^{exp_q[0].unit, exp_q[0].data}) begin n_err++; $display("FAIL rnd_par c=%0d got %0b", c, bif.RES_PAR); end
`endif
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle(); bif.OVF_CLR = 1'b1; tick();
        while (exp_q.size() > 0) begin idle(); bif.RES_READY = 1'b1; tick(); end
        for (int i = 1; i <= 3; i++) push_arith(32'(32'hA0 + i), 1'b0);
        idle();
        #2;
        rst_n = 1'b0;
        exp_q.delete(); exp_ovf = 1'b0; exp_multi = 1'b0;
        #1;
        n_cmp += 2;
        if (bif.RES_VALID !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %0b want 0", bif.RES_VALID); end
        if (bif.FIFO_COUNT !== 3'd0) begin n_err++; $display("FAIL rstmid_count got %0d want 0", bif.FIFO_COUNT); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        push_arith(32'h7, 1'b0);
        idle();
        n_cmp += 3;
        if (bif.RES_VALID !== 1'b1) begin n_err++; $display("FAIL rstmid_new_valid got %0b want 1", bif.RES_VALID); end
        if (bif.RES_DATA !== 32'h7) begin n_err++; $display("FAIL rstmid_new_data got %h want 00000007", bif.RES_DATA); end
        if (bif.FIFO_COUNT !== 3'd1) begin n_err++; $display("FAIL rstmid_new_count got %0d want 1", bif.FIFO_COUNT); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_ordering();
        test_overflow();
        test_full_push_pop();
        test_multi_flag();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Downstream stage for the 16-bit ALU. It watches the four unit result buses and their one-cycle valid flags, and selects the active result. It zero-extends that result to a common width, tags it with the producing unit, and queues it in a small FIFO. The FIFO has a valid/ready output, so a slower consumer (register file writeback, UART framer) can drain results without losing any of them.

## Interface
Parameters:
- OP_DATA_WIDTH, 16, operand width of the ALU feeding this block
- FIFO_DEPTH, 4, number of result entries; power of two, 2..16

Ports:
- CLK  input  1  single clock
- RST  input  1  asynchronous, active-low reset
- Arith_OUT  input  2*OP_DATA_WIDTH  arithmetic unit result
- Arith_Flag  input  1  arithmetic result valid this cycle
- Logic_OUT  input  OP_DATA_WIDTH  logic unit result
- Logic_Flag  input  1  logic result valid
- Shift_OUT  input  OP_DATA_WIDTH+1  shift unit result
- Shift_Flag  input  1  shift result valid
- CMP_OUT  input  2  compare unit result
- CMP_Flag  input  1  compare result valid
- RES_READY  input  1  consumer accepts the head entry
- OVF_CLR  input  1  clears the sticky OVF and MULTI_ERR flags
- RES_VALID  output  1  head entry is available
- RES_DATA  output  2*OP_DATA_WIDTH  head result, zero-extended
- RES_UNIT  output  2  head unit tag: 00 arith, 01 logic, 10 cmp, 11 shift
- FIFO_COUNT  output  $clog2(FIFO_DEPTH)+1  current occupancy
- OVF  output  1  sticky: a result was dropped because the FIFO was full
- MULTI_ERR  output  1  sticky: two or more flags were high in the same cycle

## Operation
- Push request: any flag high in a cycle.
- Source selection when more than one flag is high: fixed priority Arith > Logic > Shift > CMP.
  - Only the highest-priority result is pushed.
  - MULTI_ERR is set.
- Data formatting: the selected bus is zero-extended to 2*OP_DATA_WIDTH. No sign extension.
  - Shift_OUT keeps its carry bit at position OP_DATA_WIDTH.
- Pop: RES_VALID && RES_READY at a rising edge.
- FIFO: circular buffer.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Occupancy is tracked in an explicit count register.
- Full boundary (count == FIFO_DEPTH):
  - Push with a simultaneous pop: the push succeeds and the count is unchanged.
  - Push without a pop: the new result is dropped, OVF is set, and FIFO contents are unchanged.
- Empty boundary (count == 0): a pop is impossible because RES_VALID is 0. A push makes the count 1.
- No bypass: a result pushed at edge N is visible on RES_DATA after edge N.
- OVF_CLR:
  - Clears OVF and MULTI_ERR at the next edge.
  - If a new overflow or multi-flag event occurs in the same cycle, set wins.
- RES_DATA/RES_UNIT: driven from the head entry (show-ahead). Held stable while RES_VALID=1 and RES_READY=0.
- RES_DATA/RES_UNIT when RES_VALID=0: don't-care for checking, but the implementation drives the last head value, not X.

## Timing
- Reset (RST low, asynchronous):
  - Pointers, count, OVF and MULTI_ERR go to 0.
  - RES_VALID=0, RES_DATA=0, RES_UNIT=00, FIFO_COUNT=0.
  - Entry storage is not reset.
- Reset asserted mid-operation: all queued results are discarded immediately, with no partial pop.
- Latency: flag high in cycle N → entry written at edge ending N → RES_VALID=1 in cycle N+1 (if the FIFO was empty).
- Throughput: one push and one pop per cycle, sustained indefinitely at occupancy 1..FIFO_DEPTH.
- FIFO_COUNT, OVF and MULTI_ERR are registered and update at the same edge as the push or pop that changes them.
- RES_READY may be asserted while RES_VALID=0; this has no effect.

## Configuration
- ALU_RES_PARITY_EN:
  - When defined, each entry stores an even-parity bit over {RES_UNIT, RES_DATA}, computed at push time.
  - It is exposed as an extra output RES_PAR (1 bit, reset 0), with the same timing as RES_DATA.
- Without the macro, RES_PAR does not exist and no parity storage is built.

## Test plan
- Single push: Arith_Flag=1, Arith_OUT=0x0000_0008 for one cycle, RES_READY=0 → next cycle RES_VALID=1, RES_DATA=0x0000_0008, RES_UNIT=00, FIFO_COUNT=1. Then RES_READY=1 for one cycle → RES_VALID=0, FIFO_COUNT=0.
- Ordering and extension: back-to-back Logic_OUT=0xFFFF, Shift_OUT=0x1_0002 and CMP_OUT=2'b10 with RES_READY=1 → popped in order as 0x0000_FFFF/01, 0x0001_0002/11, 0x0000_0002/10.
- Overflow: FIFO_DEPTH=4, RES_READY=0, push 5 values 1..5 → FIFO_COUNT=4, OVF=1. Draining yields 1,2,3,4. OVF_CLR pulse → OVF=0.
- Full with simultaneous push and pop: fill with 1..4, then push 5 with RES_READY=1 in the same cycle → OVF stays 0, FIFO_COUNT=4, drain order 2,3,4,5.
- Multi-flag: Arith_Flag=1 (0x10) and Logic_Flag=1 (0x20) in the same cycle → one entry 0x10/00 is queued and MULTI_ERR=1.
- Reset mid-stream: 3 entries queued, RST pulsed low between edges → RES_VALID=0 and FIFO_COUNT=0 asynchronously. After release, a new push of 0x7 is the head.
